fd_circle_fetch: RTL and testbench
==================================

// Module: fd_circle_fetch
// PURPOSE
//  Producer side of the refAddr/refPixel/adjPixel interface consumed by feature detection.
//  - Scans every interior reference point of an image held in a synchronous byte RAM.
//  - For each point, reads the centre pixel and its 16 radius-3 Bresenham circle pixels.
//  - Presents them as one beat over a valid/ready handshake.
// PARAMETERS
//  WIDTH   256  image width in pixels (address = y*WIDTH + x)
//  HEIGHT  128  image height in pixels; WIDTH*HEIGHT <= 32768
//  BORDER  3    rows/columns skipped at each edge (circle radius)
// PORTS
//  clock      in   1    rising-edge clock
//  nReset     in   1    asynchronous active-low reset
//  start      in   1    1-cycle pulse: begin a full-image scan (ignored while busy)
//  memAddr    out  15   RAM read address
//  memRdata   in   8    RAM read data, valid exactly 1 cycle after memAddr
//  outValid   out  1    refAddr/refPixel/adjPixel hold a complete point
//  outReady   in   1    consumer accepts the beat when outValid & outReady
//  refAddr    out  15   address of the reference point
//  refPixel   out  8    centre pixel value
//  adjPixel   out  128  circle pixels; byte i = adjPixel[8i+7:8i], i = 0..15
//  busy       out  1    scan in progress
//  done       out  1    1-cycle pulse after the last point is accepted
// BEHAVIOUR
//  - Reset (async): state IDLE; memAddr, refAddr, refPixel, adjPixel = 0; outValid, busy, done = 0.
//  - Circle order, (dx,dy) for i = 0..15:
//    (0,-3)(1,-3)(2,-2)(3,-1)(3,0)(3,1)(2,2)(1,3)
//    (0,3)(-1,3)(-2,2)(-3,1)(-3,0)(-3,-1)(-2,-2)(-1,-3)
//  - Scan order: y = BORDER..HEIGHT-1-BORDER (outer), x = BORDER..WIDTH-1-BORDER (inner), raster.
//  - FSM:
//    - IDLE: on start, x = y = BORDER, busy = 1 -> FETCH.
//    - FETCH: idx 0..16 over 17 cycles.
//      - idx 0 drives the centre address, then idx k drives circle point k-1.
//      - memAddr = y*WIDTH+x + dy*WIDTH+dx, 15-bit arithmetic; operands never leave the interior.
//      - Data returned 1 cycle later is stored: idx 0 -> refPixel, idx k -> adjPixel byte k-1.
//      - After idx 16 -> WAIT.
//    - WAIT: capture the last byte (adjPixel byte 15) -> PRESENT.
//    - PRESENT: outValid = 1, outputs stable until accepted.
//      - On outValid & outReady: outValid = 0 the next cycle.
//      - If this was the last point: -> DONE. Otherwise advance x (wrap to BORDER, y+1) -> FETCH.
//    - DONE: done = 1 for one cycle, busy = 0 -> IDLE.
//  - Throughput: 19 cycles per point when outReady is held high; first outValid 19 cycles after start.
//  - outReady while outValid = 0 has no effect. A consumer stall holds PRESENT indefinitely; no data is lost.
//  - start while busy is ignored; start on the same cycle DONE is entered is also ignored.
//  - nReset asserted mid-scan: immediate return to IDLE. A new start restarts from (BORDER,BORDER).
//  - If WIDTH or HEIGHT <= 2*BORDER there are no points: start -> DONE next cycle, with done pulse and no outValid.
//  - memAddr holds its last value outside FETCH.
// TESTING (WIDTH=8, HEIGHT=8, BORDER=3; RAM byte[a] = a[7:0])
//  - Reset mid-FETCH:
//    - Expect all outputs 0 immediately.
//    - Then start: first beat refAddr=27, refPixel=27, adjPixel byte0=3, byte4=30, byte12=24, byte8=51.
//  - Full scan, outReady=1:
//    - Exactly 4 beats with refAddr 27,28,35,36, 19 cycles apart.
//    - done pulses once; busy falls with done.
//  - Backpressure: outReady=0 for 10 cycles on beat 2 -> outValid held, refAddr=28 and adjPixel stable, no beat skipped.
//  - start pulsed while busy -> ignored; total beats remain 4, scan order unchanged.
//  - WIDTH=6 (no interior columns): start -> done after 1 cycle, outValid never asserted.
//  - memAddr trace for beat 1 equals 27,3,4,13,22,30,38,45,52,51,50,41,32,24,16,9,2.

Source files
------------

// File: rtl/fd_circle_fetch.sv
// fd_circle_fetch: scans interior points of a byte image and fetches
// each centre pixel plus its 16-pixel radius-3 circle as one beat.
module fd_circle_fetch #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 128,
    parameter int BORDER = 3
) (
    input  logic         clock,
    input  logic         nReset,
    input  logic         start,
    output logic [14:0]  memAddr,
    input  logic [7:0]   memRdata,
    output logic         outValid,
    input  logic         outReady,
    output logic [14:0]  refAddr,
    output logic [7:0]   refPixel,
    output logic [127:0] adjPixel,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic        EMPTY  = (WIDTH <= 2 * BORDER) ||
                                     (HEIGHT <= 2 * BORDER);
    localparam logic [14:0] XFIRST = 15'(BORDER);
    localparam logic [14:0] YFIRST = 15'(BORDER);
    localparam logic [14:0] XLAST  = 15'(WIDTH - 1 - BORDER);
    localparam logic [14:0] YLAST  = 15'(HEIGHT - 1 - BORDER);

    state_t         r_state;
    state_t         w_next;
    logic [4:0]     r_idx;
    logic [14:0]    r_x;
    logic [14:0]    r_y;
    logic [14:0]    r_memHold;
    logic [14:0]    r_refAddr;
    logic [7:0]     r_refPixel;
    logic [127:0]   r_adjPixel;

    logic [14:0]    w_base;
    logic [3:0]     w_ci;
    logic [3:0]     w_bi;
    logic [14:0]    w_addr;
    logic           w_last;

    // Address offset of circle point i relative to the centre, mod 2^15.
    function automatic logic [14:0] f_off(input logic [3:0] i);
        int dx;
        int dy;
        dx = 0;
        dy = 0;
        case (i)
            4'd0:    begin dx =  0; dy = -3; end
            4'd1:    begin dx =  1; dy = -3; end
            4'd2:    begin dx =  2; dy = -2; end
            4'd3:    begin dx =  3; dy = -1; end
            4'd4:    begin dx =  3; dy =  0; end
            4'd5:    begin dx =  3; dy =  1; end
            4'd6:    begin dx =  2; dy =  2; end
            4'd7:    begin dx =  1; dy =  3; end
            4'd8:    begin dx =  0; dy =  3; end
            4'd9:    begin dx = -1; dy =  3; end
            4'd10:   begin dx = -2; dy =  2; end
            4'd11:   begin dx = -3; dy =  1; end
            4'd12:   begin dx = -3; dy =  0; end
            4'd13:   begin dx = -3; dy = -1; end
            4'd14:   begin dx = -2; dy = -2; end
            default: begin dx = -1; dy = -3; end
        endcase
        return 15'(dy * WIDTH + dx);
    endfunction

    assign w_base = 15'(r_y * WIDTH) + r_x;
    // idx k>0 addresses circle point k-1; idx 16 wraps to point 15.
    assign w_ci   = r_idx[3:0] - 4'd1;
    // Byte slot for data arriving at idx k>=2 is k-2.
    assign w_bi   = r_idx[3:0] - 4'd2;
    assign w_addr = w_base +
                    ((r_idx == 5'd0) ? 15'd0 : f_off(w_ci));
    assign w_last = (r_x == XLAST) && (r_y == YLAST);

    assign memAddr  = (r_state == S_FETCH) ? w_addr : r_memHold;
    assign outValid = (r_state == S_PRESENT);
    assign busy     = (r_state == S_FETCH) ||
                      (r_state == S_WAIT)  ||
                      (r_state == S_PRESENT);
    assign done     = (r_state == S_DONE);
    assign refAddr  = r_refAddr;
    assign refPixel = r_refPixel;
    assign adjPixel = r_adjPixel;

    // State register.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = EMPTY ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (r_idx == 5'd16) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (outReady) begin
                    w_next = w_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Scan position, fetch index and captured pixel data.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_idx      <= 5'd0;
            r_x        <= 15'd0;
            r_y        <= 15'd0;
            r_memHold  <= 15'd0;
            r_refAddr  <= 15'd0;
            r_refPixel <= 8'd0;
            r_adjPixel <= 128'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x   <= XFIRST;
                        r_y   <= YFIRST;
                        r_idx <= 5'd0;
                    end
                end
                S_FETCH: begin
                    r_memHold <= w_addr;
                    r_idx     <= r_idx + 5'd1;
                    if (r_idx == 5'd1) begin
                        r_refPixel <= memRdata;
                    end else if (r_idx != 5'd0) begin
                        r_adjPixel[{w_bi, 3'b000} +: 8] <= memRdata;
                    end
                end
                S_WAIT: begin
                    r_adjPixel[127:120] <= memRdata;
                    r_refAddr           <= w_base;
                end
                S_PRESENT: begin
                    if (outReady) begin
                        r_idx <= 5'd0;
                        if (!w_last) begin
                            if (r_x == XLAST) begin
                                r_x <= XFIRST;
                                r_y <= r_y + 15'd1;
                            end else begin
                                r_x <= r_x + 15'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fd_circle_fetch.sv
// tb_fd_circle_fetch: random-handshake bench for fd_circle_fetch on an
// 8x8 image (byte[a] = a[7:0]) plus a 6-wide image with no interior.
module tb_fd_circle_fetch;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int B   = 3;
    localparam int NX  = W - 2 * B;
    localparam int NY  = H - 2 * B;
    localparam int NPT = NX * NY;
    localparam int DX[16] = '{0, 1, 2, 3, 3, 3, 2, 1,
                              0, -1, -2, -3, -3, -3, -2, -1};
    localparam int DY[16] = '{-3, -3, -2, -1, 0, 1, 2, 3,
                              3, 3, 2, 1, 0, -1, -2, -3};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [14:0]  mem_addr;
    logic [7:0]   rdata;
    logic         out_valid;
    logic         out_ready;
    logic [14:0]  ref_addr;
    logic [7:0]   ref_pix;
    logic [127:0] adj;
    logic         busy;
    logic         done;

    logic         start_e;
    logic [14:0]  e_addr;
    logic [7:0]   e_rdata;
    logic         e_valid;
    logic         e_ready;
    logic [14:0]  e_ref;
    logic [7:0]   e_pix;
    logic [127:0] e_adj;
    logic         e_busy;
    logic         e_done;

    int n_total = 0;
    int n_bad   = 0;

    int           cyc = 0;
    int           cyc_start = 0;
    bit           first_pend = 0;
    int           nbeat = 0;
    int           ndone = 0;
    int           last_acc = 0;
    bit           spacing_on = 0;
    bit           prev_stall = 0;
    bit           prev_busy = 0;
    logic [14:0]  prev_ref;
    logic [7:0]   prev_pix;
    logic [127:0] prev_adj;
    logic [14:0]  smp_addr;
    logic         smp_e_done;
    bit           e_valid_seen = 0;

    always #5 clk = ~clk;

    fd_circle_fetch #(.WIDTH(W), .HEIGHT(H), .BORDER(B)) u_dut (
        .clock    (clk),
        .nReset   (rst_n),
        .start    (start),
        .memAddr  (mem_addr),
        .memRdata (rdata),
        .outValid (out_valid),
        .outReady (out_ready),
        .refAddr  (ref_addr),
        .refPixel (ref_pix),
        .adjPixel (adj),
        .busy     (busy),
        .done     (done)
    );

    fd_circle_fetch #(.WIDTH(6), .HEIGHT(H), .BORDER(B)) u_empty (
        .clock    (clk),
        .nReset   (rst_n),
        .start    (start_e),
        .memAddr  (e_addr),
        .memRdata (e_rdata),
        .outValid (e_valid),
        .outReady (e_ready),
        .refAddr  (e_ref),
        .refPixel (e_pix),
        .adjPixel (e_adj),
        .busy     (e_busy),
        .done     (e_done)
    );

    // Synchronous image RAMs: data one cycle after the address.
    always @(posedge clk) begin
        rdata   <= mem_addr[7:0];
        e_rdata <= e_addr[7:0];
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Address of fetch slot k (0 = centre, k = circle point k-1).
    function automatic logic [14:0] m_addr(int x, int y, int k);
        if (k == 0) return 15'(y * W + x);
        return 15'((y + DY[k-1]) * W + (x + DX[k-1]));
    endfunction

    function automatic int pt_x(int n);
        return B + (n % NX);
    endfunction

    function automatic int pt_y(int n);
        return B + (n / NX);
    endfunction

    function automatic logic [127:0] m_adj(int x, int y);
        logic [127:0] v;
        logic [14:0]  a;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            a = m_addr(x, y, i + 1);
            v[8*i +: 8] = a[7:0];
        end
        return v;
    endfunction

    task automatic mon();
        cyc++;
        smp_addr   = mem_addr;
        smp_e_done = e_done;
        if (e_valid) e_valid_seen = 1;
        if (start && !busy && !done) begin
            cyc_start  = cyc;
            first_pend = 1;
        end
        if (out_valid && first_pend) begin
            chk("first_latency", cyc - cyc_start, 19);
            first_pend = 0;
        end
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_ref", ref_addr, prev_ref);
            chk("stall_pix", ref_pix, prev_pix);
            chk("stall_adj", adj, prev_adj);
        end
        if (out_valid && out_ready) begin
            if (nbeat < NPT) begin
                chk("beat_ref", ref_addr,
                    m_addr(pt_x(nbeat), pt_y(nbeat), 0));
                chk("beat_pix", ref_pix,
                    8'((pt_y(nbeat) * W + pt_x(nbeat)) % 256));
                chk("beat_adj", adj,
                    m_adj(pt_x(nbeat), pt_y(nbeat)));
            end else begin
                chk("beat_overflow", nbeat + 1, NPT);
            end
            if (spacing_on && nbeat > 0)
                chk("beat_spacing", cyc - last_acc, 19);
            last_acc = cyc;
            nbeat++;
        end
        if (done) begin
            ndone++;
            chk("busy_at_done", busy, 0);
            chk("busy_before_done", prev_busy, 1);
            chk("beats_at_done", nbeat, NPT);
        end
        prev_busy  = busy;
        prev_stall = out_valid && !out_ready;
        prev_ref   = ref_addr;
        prev_pix   = ref_pix;
        prev_adj   = adj;
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_e = 1'b0;
    endtask

    task automatic run_scan(input int mode);
        int  stall;
        bit  fin;
        nbeat      = 0;
        ndone      = 0;
        stall      = 0;
        fin        = 0;
        spacing_on = (mode == 0);
        out_ready  = 1'b1;
        start      = 1'b1;
        step();
        for (int k = 0; k < 800 && !fin; k++) begin
            if (mode == 1) begin
                out_ready = !(out_valid && nbeat == 1 && stall < 10);
                if (!out_ready) stall++;
            end else if (mode == 2) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if ((busy || done) && $urandom_range(0, 7) == 0)
                    start = 1'b1;
            end
            step();
            if (mode == 0 && k < 17)
                chk("addr_trace", smp_addr, m_addr(B, B, k));
            if (ndone > 0) fin = 1;
        end
        if (!fin) chk("scan_timeout", 0, 1);
        repeat (3) step();
        chk("beats", nbeat, NPT);
        chk("done_pulses", ndone, 1);
        chk("idle_busy", busy, 0);
        if (mode == 1) chk("stall_cycles", stall, 10);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d", n_total);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        start_e   = 1'b0;
        out_ready = 1'b0;
        e_ready   = 1'b1;
        repeat (3) step();
        chk("rst_ctrl", {out_valid, busy, done}, 0);
        chk("rst_addr", {mem_addr, ref_addr, ref_pix}, 0);
        chk("rst_adj", adj, 0);
        rst_n = 1'b1;
        step();

        out_ready = 1'b1;
        start     = 1'b1;
        step();
        repeat (5) step();
        chk("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ctrl", {out_valid, busy, done}, 0);
        chk("async_addr", {mem_addr, ref_addr, ref_pix}, 0);
        chk("async_adj", adj, 0);
        step();
        rst_n = 1'b1;
        step();

        run_scan(0);
        run_scan(1);
        for (int r = 0; r < 4; r++) run_scan(2);
        run_scan(0);

        start_e = 1'b1;
        step();
        step();
        chk("empty_done", smp_e_done, 1);
        step();
        chk("empty_done_once", smp_e_done, 0);
        chk("empty_busy", e_busy, 0);
        chk("empty_no_valid", e_valid_seen, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
